// File: rtl/muldiv_unit_if.sv
// Bundle of the request/response signals between the execute stage and
// the iterative multiply/divide unit.
//   master : pipeline side (drives start/op/a/b/cancel/hi_we/lo_we/wdata)
//   slave  : muldiv_unit side (drives busy/done/div_by_zero/hi/lo)
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with private HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : muldiv_unit_if.slave
//          in : start, op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), a, b,
//               cancel (pipeline flush), hi_we/lo_we/wdata (MTHI/MTLO)
//          out: busy, done (1-cycle pulse), div_by_zero (with done), hi, lo
// An operation takes WIDTH CALC steps plus one FIX (sign correction) cycle,
// then one DONE cycle in which a new start is accepted back-to-back.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 div_reg;      // operation in flight is a divide
  logic                 sign_q_reg;   // negate product / quotient
  logic                 sign_r_reg;   // negate remainder
  logic                 divz_reg;     // divisor was zero
  logic [WIDTH-1:0]     opnd_reg;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  logic                 op_signed;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic                 accept;
  logic                 busy;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;

  assign op_signed = ~bus.op[0];
  assign abs_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign abs_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign busy   = (state_reg == S_CALC) || (state_reg == S_FIX);
  assign accept = ((state_reg == S_IDLE) || (state_reg == S_DONE)) &&
                  bus.start && !bus.cancel;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE, S_DONE: state_next = accept ? S_CALC : S_IDLE;
      S_CALC: begin
        if (bus.cancel)               state_next = S_IDLE;
        else if (cnt_reg == CNT_ONE)  state_next = S_FIX;
      end
      S_FIX:   state_next = bus.cancel ? S_IDLE : S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // One radix-2 step.
  // Multiply: acc = {partial, multiplier}; add multiplicand into the upper
  // half when the multiplier LSB is set, then shift right keeping the carry.
  // Divide: acc = {remainder, dividend/quotient}; shift left and trial
  // subtract. The shifted remainder needs WIDTH+1 bits because it can reach
  // twice the divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_reg};
    div_ge    = (div_trial >= {1'b0, opnd_reg});
    if (div_reg) begin
      acc_next[WIDTH-1:0]       = {acc_reg[WIDTH-2:0], div_ge};
      acc_next[2*WIDTH-1:WIDTH] = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  // Sign correction. For a zero divisor the quotient is forced to all ones;
  // the remainder equals |a| there, so the usual remainder negation hands
  // back the original dividend unchanged.
  always_comb begin
    fix_hi = acc_reg[2*WIDTH-1:WIDTH];
    fix_lo = acc_reg[WIDTH-1:0];
    if (div_reg) begin
      if (divz_reg)        fix_lo = {WIDTH{1'b1}};
      else if (sign_q_reg) fix_lo = -acc_reg[WIDTH-1:0];
      if (sign_r_reg)      fix_hi = -acc_reg[2*WIDTH-1:WIDTH];
    end else if (sign_q_reg) begin
      {fix_hi, fix_lo} = -acc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      div_reg    <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      divz_reg   <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      if (accept) begin
        cnt_reg    <= CNT_INIT;
        div_reg    <= bus.op[1];
        sign_q_reg <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        sign_r_reg <= op_signed & bus.a[WIDTH-1];
        divz_reg   <= (bus.b == '0);
        opnd_reg   <= bus.op[1] ? abs_b : abs_a;
        acc_reg    <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
      end else if (state_reg == S_CALC) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg - CNT_ONE;
      end

      if (state_reg == S_FIX && !bus.cancel) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end else if (!busy) begin
        if (bus.hi_we) hi_reg <= bus.wdata;
        if (bus.lo_we) lo_reg <= bus.wdata;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = (state_reg == S_DONE);
  assign bus.div_by_zero = (state_reg == S_DONE) && div_reg && divz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS-style HI/LO semantics from plain arithmetic.
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rdz);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, p, uq, ur;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    rdz = 1'b0;
    rhi = '0;
    rlo = '0;
    case (op)
      2'b00: begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = ua * ub; rhi = p[63:32]; rlo = p[31:0]; end
      default: begin
        if (b == '0) begin
          rdz = 1'b1;
          rlo = '1;
          rhi = a;
        end else if (op == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          rlo = sq[31:0]; rhi = sr[31:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          rlo = uq[31:0]; rhi = ur[31:0];
        end
      end
    endcase
  endfunction

  // Issue one operation from the current cycle (IDLE or DONE) and wait for
  // its done pulse; returns in the DONE cycle.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] rh, rl;
    logic rz;
    int t, busy_cnt;
    bit seen;
    ref_op(op, a, b, rh, rl, rz);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    step();
    bus.start = 1'b0;
    t = 0; busy_cnt = 0; seen = 0;
    while (t < W + 8) begin
      if (bus.done) begin seen = 1; break; end
      if (bus.busy) busy_cnt++;
      step();
      t++;
    end
    if (!seen) begin
      check_val("done_timeout", 64'd0, 64'd1);
      return;
    end
    check_val("latency", 64'(t), 64'(W + 1));
    check_val("busy_cycles", 64'(busy_cnt), 64'(W + 1));
    check_val("busy_in_done", 64'(bus.busy), 64'd0);
    check_val("hi", 64'(bus.hi), 64'(rh));
    check_val("lo", 64'(bus.lo), 64'(rl));
    check_val("div_by_zero", 64'(bus.div_by_zero), 64'(rz));
    exp_hi = rh;
    exp_lo = rl;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b", op, a, b, bus.hi, bus.lo, bus.div_by_zero);
  endtask

  task automatic direct_write(input bit wh, input bit wl, input logic [W-1:0] d);
    bus.hi_we = wh; bus.lo_we = wl; bus.wdata = d;
    step();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    if (wh) exp_hi = d;
    if (wl) exp_lo = d;
    check_val("wr_hi", 64'(bus.hi), 64'(exp_hi));
    check_val("wr_lo", 64'(bus.lo), 64'(exp_lo));
    check_val("wr_done_low", 64'(bus.done), 64'd0);
    $display("write hi_we=%0b lo_we=%0b data=%h -> hi=%h lo=%h", wh, wl, d, bus.hi, bus.lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    // Reset state
    repeat (3) step();
    check_val("rst_hi", 64'(bus.hi), 64'd0);
    check_val("rst_lo", 64'(bus.lo), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_dz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b1;
    step();

    // Directed cases
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    check_val("mult_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFF1);
    step();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2);            // back-to-back from DONE
    step();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    do_op(2'b11, 32'd7, 32'd0);
    do_op(2'b11, 32'd7, 32'd2);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0);            // signed divide by zero

    // Direct write in DONE overrides the fresh result
    direct_write(1'b0, 1'b1, 32'hCAFE_F00D);

    // Cancel mid-CALC; hi_we while busy is ignored
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    step();
    bus.hi_we = 1'b0;
    check_val("hi_we_busy", 64'(bus.hi), 64'(exp_hi));
    repeat (4) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check_val("cancel_busy", 64'(bus.busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (bus.done) done_seen++;
      step();
    end
    check_val("cancel_no_done", 64'(done_seen), 64'd0);
    check_val("cancel_hi", 64'(bus.hi), 64'(exp_hi));
    check_val("cancel_lo", 64'(bus.lo), 64'(exp_lo));
    $display("cancel: hi=%h lo=%h", bus.hi, bus.lo);

    // cancel together with start in IDLE and in DONE: start is dropped
    bus.start = 1'b1; bus.cancel = 1'b1;
    step();
    bus.start = 1'b0; bus.cancel = 1'b0;
    check_val("cancel_start_idle", 64'(bus.busy), 64'd0);
    do_op(2'b00, 32'd9, 32'hFFFF_FFFE);
    bus.start = 1'b1; bus.cancel = 1'b1;
    step();
    bus.start = 1'b0; bus.cancel = 1'b0;
    check_val("cancel_start_done", 64'(bus.busy), 64'd0);

    // Both direct writes at once in IDLE
    direct_write(1'b1, 1'b1, 32'h1357_9BDF);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [1:0] rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      do_op(rop, ra, rb);
      if ($urandom_range(0, 3) == 0)
        direct_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) step();
    end

    // Asynchronous reset mid-CALC
    direct_write(1'b1, 1'b1, 32'hA5A5_5A5A);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = $urandom; bus.b = $urandom;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    #1 rst = 1'b0;
    #1;
    check_val("arst_hi", 64'(bus.hi), 64'd0);
    check_val("arst_lo", 64'(bus.lo), 64'd0);
    check_val("arst_busy", 64'(bus.busy), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    step();
    rst = 1'b1;
    step();
    direct_write(1'b1, 1'b0, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit with its own HI/LO result registers, parametrised in operand width.
- Sits beside the execute-stage ALU and replaces the single-cycle combinational multiply.
- Adds signed/unsigned division, a start/busy/done handshake for pipeline stalling, pipeline-flush cancel, and direct HI/LO writes for MTHI/MTLO.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled at rising edge.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- cancel  in  1  pipeline flush; aborts operation in flight.
- hi_we  in  1  direct HI write (MTHI).
- lo_we  in  1  direct LO write (MTLO).
- wdata  in  WIDTH  data for hi_we/lo_we.
- busy  out  1  operation in flight; pipeline stalls while high.
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- div_by_zero  out  1  qualified by done; divisor was zero.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
- State IDLE:
  - start=1 and cancel=0 → latch op and operands, cnt=WIDTH → CALC.
  - Signed ops latch |a| and |b|, plus sign_q=a[W-1]^b[W-1] and sign_r=a[W-1].
- State CALC: one radix-2 step per cycle, cnt decrements.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, quotient and remainder in a 2·WIDTH register.
  - Leaves for FIX on the edge where cnt==1.
- State FIX, one cycle: sign correction; hi/lo written at exit edge → DONE.
  - MULT: negate the 2·WIDTH product if sign_q.
  - DIV: negate quotient if sign_q; negate remainder if sign_r.
  - Multiply: {hi,lo}=product. Divide: lo=quotient, hi=remainder.
- State DONE: done=1 for exactly one cycle → IDLE.
  - start in DONE is accepted as in IDLE, giving back-to-back operation.
- busy=1 in CALC and FIX only.
- Latency: start edge k → done high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles later.
- start while busy is ignored.
- Divide by zero: lo = all ones, hi = a unchanged, no sign fixup, div_by_zero=1 with done. Not an exception.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0. Falls out of the unsigned magnitude path; no special case.
- cancel=1 in CALC or FIX → IDLE at next edge. hi/lo untouched, no done.
  - cancel with start in IDLE/DONE: cancel wins, start ignored.
- hi_we/lo_we honoured only when busy=0; ignored while busy.
  - In DONE, a direct write overrides the just-written result on that edge.
  - hi_we and lo_we may be asserted together.
- hi/lo hold their value except on FIX exit or a direct write.
- Widths: products are exact 2·WIDTH bits; negation is two's complement modulo 2^WIDTH per half for divide, 2^(2·WIDTH) for multiply.

Test Plan:
- WIDTH=32, MULT a=FFFFFFFD (-3), b=5 → done after 34 cycles, hi=FFFFFFFF, lo=FFFFFFF1, busy high for 33 cycles.
- MULTU a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. Back-to-back start asserted in the DONE cycle → second result without an IDLE gap.
- DIV a=FFFFFFF9 (-7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- DIVU a=7, b=0 → lo=FFFFFFFF, hi=7, div_by_zero=1 with done. Following DIVU 7/2 → lo=3, hi=1, div_by_zero=0.
- MULTU 2×3 started, cancel at cycle 10 → IDLE next edge, no done. hi/lo keep the prior values. hi_we during CALC is ignored.
- rst low mid-CALC → hi=lo=0 and busy=0 immediately, asynchronously. After release, hi_we wdata=1234 → hi=1234, lo=0.
